filter_sample_sequencer: RTL and testbench
==========================================

Name: filter_sample_sequencer

Overview:
- Drives the sample side of a `filter_sos` cascade top (e.g. the high-pass top).
- Generates a periodic `sample_trig` from a programmable clock divider. Presents a held input sample and waits for `filter_done`.
- Captures the filtered result into a valid/ready output stream.
- Reports overrun, underrun, timeout and sink-overflow status.

Parameters:
- DATA_SIZE, 24, sample width; matches the filter `data_in`/`data_out` width.
- DIV_WIDTH, 16, width of the sample-period divider.
- TIMEOUT, 1023, maximum clk cycles spent in WAIT before aborting.
- CNT_WIDTH, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run control for the divider.
- rate_div  in  DIV_WIDTH  sample period in clk cycles, minus 1.
- clear_err  in  1  single-cycle pulse; clears all status outputs.
- src_data  in  DATA_SIZE  upstream sample.
- src_valid  in  1  upstream valid.
- src_ready  out  1  upstream ready.
- flt_data_in  out  DATA_SIZE  to filter `data_in`.
- flt_sample_trig  out  1  to filter `sample_trig`.
- flt_done  in  1  from filter `filter_done`.
- flt_data_out  in  DATA_SIZE  from filter `data_out`.
- snk_data  out  DATA_SIZE  filtered sample.
- snk_valid  out  1  downstream valid.
- snk_ready  in  1  downstream ready.
- busy  out  1  high while the FSM is in TRIG or WAIT.
- overrun_cnt  out  CNT_WIDTH  saturating count of dropped ticks.
- underrun  out  1  sticky flag.
- timeout_err  out  1  sticky flag.
- sink_ovf  out  1  sticky flag.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE, `tick_pending` cleared, input register empty, divider at 0.
- Reset mid-operation: any in-flight filter result is discarded.
- Divider:
  - Counts 0..`rate_div` while `enable`=1 and emits a 1-cycle tick on wrap.
  - A new `rate_div` value takes effect at the next wrap.
  - `enable`=0 holds the divider at 0, emits no ticks and clears `tick_pending`. An in-flight WAIT still completes.
- Input register:
  - One entry; `src_ready` = not full.
  - Loaded on `src_valid` & `src_ready`; emptied on the cycle TRIG is entered.
- FSM states: IDLE, TRIG, WAIT.
  - IDLE: on tick or `tick_pending`, go to TRIG and clear `tick_pending`.
    - If the input register is full: copy it to the hold register and empty the input register.
    - Otherwise: reuse the previous hold value and set `underrun`.
  - TRIG: lasts exactly 1 cycle; `flt_sample_trig`=1 is a registered output. Then go to WAIT.
    - Latency: tick cycle T gives `flt_sample_trig` high in cycle T+1.
  - WAIT: timeout counter increments each cycle.
    - On `flt_done`=1: register `flt_data_out` into the output register, set `snk_valid`, go to IDLE.
    - If the counter reaches TIMEOUT first: set `timeout_err`, discard the sample, go to IDLE.
- `flt_data_in` always drives the hold register. It is stable from TRIG until WAIT exits.
- Ticks outside IDLE:
  - A tick sets `tick_pending`.
  - A tick while `tick_pending` is already set increments `overrun_cnt`, saturating at all-ones, and the tick is dropped.
- Tick and `flt_done` in the same cycle: the done is processed and the tick sets `tick_pending`. TRIG follows 1 cycle after IDLE is entered.
- Output:
  - `snk_valid` is held until `snk_ready`=1; it is cleared on the handshake cycle.
  - A new result arriving while `snk_valid`=1 and not accepted that cycle overwrites `snk_data` and sets `sink_ovf`.
  - Result arrival coinciding with a handshake is not an overflow; `snk_valid` stays 1 with the new data.
- `flt_done` seen outside WAIT is ignored.
- `clear_err` clears `overrun_cnt` and all three flags. If an error event occurs in the same cycle, the event wins.
- `rate_div`=0 gives a tick every cycle; overrun counting then becomes continuous.

Decomposition:
- Package `filter_seq_pkg`:
  - FSM state encoding (IDLE, TRIG, WAIT).
  - Default DATA_SIZE and timeout constants.
- Sub-module `sample_rate_divider`: counter plus tick output, with `enable` and `rate_div` inputs.
- Everything else stays in the top.

Test Plan:
- `rate_div`=99, src streams 1,2,3, filter model answers `flt_done` 20 cycles after trig with data×2:
  - `flt_sample_trig` occurs every 100 cycles, each exactly 1 cycle wide.
  - `snk_data` = 2, 4, 6.
  - `overrun_cnt`=0 and all flags 0.
- `rate_div`=9, filter latency 35 cycles:
  - the first tick in WAIT sets pending; subsequent ticks increment `overrun_cnt` up to 255, then it saturates.
  - `clear_err` returns it to 0.
- `src_valid` held 0 at a tick → trig is issued with the previous sample, `underrun`=1.
- `flt_done` never asserted → after 1023 WAIT cycles `timeout_err`=1, FSM returns to IDLE and `snk_valid` stays 0.
- `snk_ready`=0 across two results (0x000010 then 0x000020) → `snk_data`=0x000020 and `sink_ovf`=1.
- Reset deasserted during WAIT → all outputs 0 immediately; after release, normal triggering resumes on the first tick.

Source files
------------

// File: rtl/filter_seq_pkg.sv
// filter_seq_pkg: shared state encoding and default sizing for the filter sample sequencer.
// Rev 1.0
`default_nettype none

package filter_seq_pkg;

  localparam int DEF_DATA_SIZE = 24;
  localparam int DEF_TIMEOUT   = 1023;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_WAIT = 2'd2
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/sample_rate_divider.sv
// sample_rate_divider: free-running 0..rate_div counter emitting a one-cycle tick on wrap.
// Rev 1.0
`default_nettype none

module sample_rate_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic [DIV_WIDTH-1:0] i_rate_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_limit;
  logic                 w_wrap;

  assign w_wrap = i_enable && (r_cnt == r_limit);
  assign o_tick = w_wrap;

  // The period is sampled only while stopped or on wrap, so a new rate never
  // truncates or stretches the period already in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_limit <= '0;
    end else if (!i_enable) begin
      r_cnt   <= '0;
      r_limit <= i_rate_div;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_limit <= i_rate_div;
    end else begin
      r_cnt   <= r_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/filter_sample_sequencer.sv
// filter_sample_sequencer: paces samples into a filter_sos cascade, collects results onto a
// valid/ready stream and reports overrun/underrun/timeout/sink-overflow status. Rev 1.0
`default_nettype none

module filter_sample_sequencer
  import filter_seq_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int DIV_WIDTH = 16,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic [DIV_WIDTH-1:0] i_rate_div,
  input  logic                 i_clear_err,
  input  logic [DATA_SIZE-1:0] i_src_data,
  input  logic                 i_src_valid,
  output logic                 o_src_ready,
  output logic [DATA_SIZE-1:0] o_flt_data_in,
  output logic                 o_flt_sample_trig,
  input  logic                 i_flt_done,
  input  logic [DATA_SIZE-1:0] i_flt_data_out,
  output logic [DATA_SIZE-1:0] o_snk_data,
  output logic                 o_snk_valid,
  input  logic                 i_snk_ready,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_overrun_cnt,
  output logic                 o_underrun,
  output logic                 o_timeout_err,
  output logic                 o_sink_ovf
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  seq_state_t           r_state, w_state_nxt;
  logic                 w_tick, w_enter_trig, w_result, w_abort;
  logic                 w_tick_busy, w_overrun, w_load, w_in_full_nxt;
  logic                 r_tick_pending, r_in_full, r_src_ready, r_trig;
  logic [DATA_SIZE-1:0] r_in_data, r_hold, r_snk_data;
  logic                 r_snk_valid, r_underrun, r_timeout, r_sink_ovf;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic [CNT_WIDTH-1:0] r_ovr_cnt;

  sample_rate_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_enable   (i_enable),
    .i_rate_div (i_rate_div),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_enter_trig = 1'b0;
    w_result     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: if (w_tick || r_tick_pending) begin
        w_state_nxt  = S_TRIG;
        w_enter_trig = 1'b1;
      end
      S_TRIG: w_state_nxt = S_WAIT;
      S_WAIT: if (i_flt_done) begin
        w_result    = 1'b1;
        w_state_nxt = S_IDLE;
      end else if (r_tmo_cnt == TMO_LAST) begin
        w_abort     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_tick_busy   = w_tick && (r_state != S_IDLE);
  assign w_overrun     = w_tick_busy && r_tick_pending;
  assign w_load        = i_src_valid && r_src_ready;
  assign w_in_full_nxt = w_load || (r_in_full && !w_enter_trig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_tick_pending <= 1'b0;
      r_in_full      <= 1'b0;
      r_src_ready    <= 1'b0;
      r_in_data      <= '0;
      r_hold         <= '0;
      r_trig         <= 1'b0;
      r_tmo_cnt      <= '0;
      r_snk_data     <= '0;
      r_snk_valid    <= 1'b0;
      r_ovr_cnt      <= '0;
      r_underrun     <= 1'b0;
      r_timeout      <= 1'b0;
      r_sink_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_trig  <= w_enter_trig;

      // Pending tick plus a fresh tick in IDLE: one is consumed, the other stays queued.
      if (!i_enable)         r_tick_pending <= 1'b0;
      else if (w_enter_trig) r_tick_pending <= r_tick_pending && w_tick;
      else if (w_tick_busy)  r_tick_pending <= 1'b1;

      // Ready is registered so it reads 0 under reset and mirrors !full afterwards.
      r_in_full   <= w_in_full_nxt;
      r_src_ready <= !w_in_full_nxt;
      if (w_load) r_in_data <= i_src_data;
      if (w_enter_trig && r_in_full) r_hold <= r_in_data;

      if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      else                   r_tmo_cnt <= '0;

      if (w_result) begin
        r_snk_data  <= i_flt_data_out;
        r_snk_valid <= 1'b1;
      end else if (r_snk_valid && i_snk_ready) begin
        r_snk_valid <= 1'b0;
      end

      if (w_overrun) begin
        if (r_ovr_cnt != '1) r_ovr_cnt <= r_ovr_cnt + CNT_WIDTH'(1);
      end else if (i_clear_err) begin
        r_ovr_cnt <= '0;
      end

      if (w_enter_trig && !r_in_full) r_underrun <= 1'b1;
      else if (i_clear_err)           r_underrun <= 1'b0;

      if (w_abort)          r_timeout <= 1'b1;
      else if (i_clear_err) r_timeout <= 1'b0;

      if (w_result && r_snk_valid && !i_snk_ready) r_sink_ovf <= 1'b1;
      else if (i_clear_err)                         r_sink_ovf <= 1'b0;
    end
  end

  assign o_src_ready       = r_src_ready;
  assign o_flt_data_in     = r_hold;
  assign o_flt_sample_trig = r_trig;
  assign o_snk_data        = r_snk_data;
  assign o_snk_valid       = r_snk_valid;
  assign o_busy            = (r_state != S_IDLE);
  assign o_overrun_cnt     = r_ovr_cnt;
  assign o_underrun        = r_underrun;
  assign o_timeout_err     = r_timeout;
  assign o_sink_ovf        = r_sink_ovf;

endmodule

`default_nettype wire

// File: tb/tb_filter_sample_sequencer.sv
// tb_filter_sample_sequencer: scenario tasks with a result scoreboard and a behavioural filter model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_filter_sample_sequencer;

  localparam int DW = 24;
  localparam int VW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_enable, i_clear_err, i_src_valid, i_snk_ready;
  logic [VW-1:0] i_rate_div;
  logic [DW-1:0] i_src_data;
  logic          o_src_ready, o_flt_sample_trig, o_snk_valid, o_busy;
  logic [DW-1:0] o_flt_data_in, o_snk_data;
  logic          flt_done;
  logic [DW-1:0] flt_data_out;
  logic [CW-1:0] o_overrun_cnt;
  logic          o_underrun, o_timeout_err, o_sink_ovf;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] resp_q[$];
  logic [DW-1:0] sb_exp;
  int            flt_lat = 20;
  bit            flt_en  = 1'b1;
  bit            sb_on   = 1'b1;

  always #5 clk = ~clk;

  filter_sample_sequencer #(
    .DATA_SIZE (DW),
    .DIV_WIDTH (VW),
    .TIMEOUT   (1023),
    .CNT_WIDTH (CW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_enable          (i_enable),
    .i_rate_div        (i_rate_div),
    .i_clear_err       (i_clear_err),
    .i_src_data        (i_src_data),
    .i_src_valid       (i_src_valid),
    .o_src_ready       (o_src_ready),
    .o_flt_data_in     (o_flt_data_in),
    .o_flt_sample_trig (o_flt_sample_trig),
    .i_flt_done        (flt_done),
    .i_flt_data_out    (flt_data_out),
    .o_snk_data        (o_snk_data),
    .o_snk_valid       (o_snk_valid),
    .i_snk_ready       (i_snk_ready),
    .o_busy            (o_busy),
    .o_overrun_cnt     (o_overrun_cnt),
    .o_underrun        (o_underrun),
    .o_timeout_err     (o_timeout_err),
    .o_sink_ovf        (o_sink_ovf)
  );

  // Filter model: answers flt_lat cycles after trig with 2*data_in, or a queued response.
  initial begin : filter_model
    int            cnt;
    logic [DW-1:0] pend;
    cnt = 0;
    pend = '0;
    flt_done = 1'b0;
    flt_data_out = '0;
    forever begin
      @(negedge clk);
      flt_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (o_flt_sample_trig) begin
        cnt = flt_lat;
        if (resp_q.size() > 0) pend = resp_q.pop_front();
        else                   pend = o_flt_data_in << 1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && flt_en) begin
          flt_done = 1'b1;
          flt_data_out = pend;
        end
      end
    end
  end

  // Scoreboard pop side: every sink handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (rst_n && sb_on && o_snk_valid && i_snk_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sink_unexpected got=%h req=none", o_snk_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (o_snk_data !== sb_exp) begin
          failures++;
          $display("FAIL sink_data got=%h req=%h", o_snk_data, sb_exp);
        end
      end
    end
  end

  task automatic do_reset();
    i_enable = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_trig(input int bound, input string name);
    int n = 0;
    while (!o_flt_sample_trig && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!o_flt_sample_trig) begin
      checks++;
      failures++;
      $display("FAIL %s_trig_timeout got=none req=trig within %0d cycles", name, bound);
    end
  endtask

  task automatic test_reset();
    i_enable = 0; i_rate_div = '0; i_clear_err = 0; i_src_data = '0;
    i_src_valid = 0; i_snk_ready = 1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_src_ready, o_flt_data_in, o_flt_sample_trig, o_snk_data, o_snk_valid, o_busy,
         o_overrun_cnt, o_underrun, o_timeout_err, o_sink_ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=nonzero req=all zero (ready=%b busy=%b)", o_src_ready, o_busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_src_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got=ready%b busy%b req=ready1 busy0", o_src_ready, o_busy);
    end
  endtask

  task automatic test_stream();
    int            idx = 0;
    int            wide = 0;
    bit            prev = 0;
    int            trig_cyc[$];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] e;
    flt_lat = 20; sb_on = 1; i_snk_ready = 1; i_rate_div = 16'd99;
    @(negedge clk);
    i_enable = 1;
    for (int cyc = 0; cyc < 360; cyc++) begin
      @(negedge clk);
      if (o_flt_sample_trig) begin
        if (prev) begin
          wide++;
        end else begin
          trig_cyc.push_back(cyc);
          e = (src_q.size() > 0) ? src_q.pop_front() : 'x;
          checks++;
          if (o_flt_data_in !== e) begin
            failures++;
            $display("FAIL stream_flt_in got=%h req=%h", o_flt_data_in, e);
          end
        end
      end
      prev = o_flt_sample_trig;
      i_src_valid = (idx < 3);
      i_src_data = DW'(idx + 1);
      if (i_src_valid && o_src_ready) begin
        src_q.push_back(i_src_data);
        exp_q.push_back(DW'((idx + 1) * 2));
        idx++;
      end
    end
    i_src_valid = 0;
    i_enable = 0;
    checks++;
    if (trig_cyc.size() != 3) begin
      failures++;
      $display("FAIL stream_trig_count got=%0d req=3", trig_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (trig_cyc[i] - trig_cyc[i-1] != 100) begin
          failures++;
          $display("FAIL stream_trig_period got=%0d req=100", trig_cyc[i] - trig_cyc[i-1]);
        end
      end
    end
    checks++;
    if (wide != 0) begin
      failures++;
      $display("FAIL stream_trig_width got=%0d wide cycles req=0", wide);
    end
    checks++;
    if ({o_overrun_cnt, o_underrun, o_timeout_err, o_sink_ovf} !== '0) begin
      failures++;
      $display("FAIL stream_status got=ovr%0d u%b t%b s%b req=all 0",
               o_overrun_cnt, o_underrun, o_timeout_err, o_sink_ovf);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL stream_results_left got=%0d req=0", exp_q.size());
    end
  endtask

  task automatic test_underrun();
    @(negedge clk);
    checks++;
    if (o_underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_pre got=%b req=0", o_underrun);
    end
    exp_q.push_back(DW'(6));
    i_enable = 1;
    wait_trig(200, "underrun");
    checks++;
    if (o_flt_data_in !== DW'(3) || o_underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_trig got=data%h u%b req=data000003 u1", o_flt_data_in, o_underrun);
    end
    repeat (40) @(negedge clk);
    i_enable = 0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL underrun_result_left got=%0d req=0", exp_q.size());
    end
  endtask

  task automatic test_overrun();
    int t1 = -1, t2 = -1, nonmono = 0, n = 0;
    bit seen_valid = 0;
    logic [CW-1:0] last = '0;
    do_reset();
    sb_on = 0; flt_lat = 35; i_rate_div = 16'd9; i_snk_ready = 1;
    @(negedge clk);
    i_enable = 1;
    while (o_overrun_cnt !== 8'hFF && n < 20000) begin
      @(negedge clk);
      n++;
      if (o_flt_sample_trig) begin
        if (t1 < 0) t1 = n;
        else if (t2 < 0) t2 = n;
      end
      if (o_snk_valid && !seen_valid) begin
        seen_valid = 1;
        checks++;
        if (o_overrun_cnt !== 8'd2) begin
          failures++;
          $display("FAIL overrun_first_service got=%0d req=2", o_overrun_cnt);
        end
      end
      if (o_overrun_cnt < last) nonmono++;
      last = o_overrun_cnt;
    end
    checks++;
    if (t2 - t1 != 37) begin
      failures++;
      $display("FAIL overrun_pending_trig got=%0d req=37", t2 - t1);
    end
    checks++;
    if (o_overrun_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL overrun_reach_max got=%0d req=255", o_overrun_cnt);
    end
    repeat (300) begin
      @(negedge clk);
      if (o_overrun_cnt !== 8'hFF) nonmono++;
    end
    checks++;
    if (nonmono != 0) begin
      failures++;
      $display("FAIL overrun_saturate got=%0d bad cycles req=0", nonmono);
    end
    i_enable = 0;
    n = 0;
    while (o_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    i_clear_err = 1;
    @(negedge clk);
    i_clear_err = 0;
    checks++;
    if ({o_overrun_cnt, o_underrun} !== '0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got=ovr%0d u%b busy%b req=0 0 0", o_overrun_cnt, o_underrun, o_busy);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit busy_late = 0;
    do_reset();
    sb_on = 0; flt_en = 0; i_rate_div = 16'd2047;
    @(negedge clk);
    i_enable = 1;
    wait_trig(2200, "timeout");
    i_enable = 0;
    while (!o_timeout_err && n < 1100) begin
      @(negedge clk);
      n++;
      if (n == 1023) busy_late = o_busy;
    end
    checks++;
    if (n != 1024) begin
      failures++;
      $display("FAIL timeout_latency got=%0d req=1024", n);
    end
    checks++;
    if (busy_late !== 1'b1 || o_busy !== 1'b0 || o_snk_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_exit got=late%b busy%b valid%b req=1 0 0", busy_late, o_busy, o_snk_valid);
    end
    i_clear_err = 1;
    @(negedge clk);
    i_clear_err = 0;
    checks++;
    if (o_timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear got=%b req=0", o_timeout_err);
    end
    flt_en = 1;
  endtask

  task automatic test_sink_ovf();
    int n = 0;
    bit first = 0;
    do_reset();
    sb_on = 1; i_snk_ready = 0; flt_lat = 20; i_rate_div = 16'd99;
    resp_q.push_back(DW'(24'h000010));
    resp_q.push_back(DW'(24'h000020));
    exp_q.push_back(DW'(24'h000020));
    @(negedge clk);
    i_enable = 1;
    while (!o_sink_ovf && n < 400) begin
      @(negedge clk);
      n++;
      if (o_snk_valid && !first) begin
        first = 1;
        checks++;
        if (o_snk_data !== 24'h000010 || o_sink_ovf !== 1'b0) begin
          failures++;
          $display("FAIL ovf_first got=%h ovf%b req=000010 ovf0", o_snk_data, o_sink_ovf);
        end
      end
    end
    i_enable = 0;
    checks++;
    if (o_sink_ovf !== 1'b1 || o_snk_data !== 24'h000020 || o_snk_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovf_overwrite got=%h ovf%b v%b req=000020 ovf1 v1", o_snk_data, o_sink_ovf, o_snk_valid);
    end
    i_snk_ready = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_snk_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ovf_drain got=v%b left%0d req=v0 left0", o_snk_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_midwait();
    int n = 0;
    do_reset();
    sb_on = 1; flt_lat = 35; i_rate_div = 16'd99; i_snk_ready = 1;
    i_src_valid = 1; i_src_data = DW'(5);
    do begin @(negedge clk); n++; end while (!o_src_ready && n < 10);
    @(negedge clk);
    i_src_valid = 0;
    i_enable = 1;
    wait_trig(200, "midwait");
    repeat (10) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1 || o_flt_data_in !== DW'(5)) begin
      failures++;
      $display("FAIL midwait_pre got=busy%b data%h req=busy1 data000005", o_busy, o_flt_data_in);
    end
    rst_n = 0;
    i_enable = 0;
    #1;
    checks++;
    if ({o_src_ready, o_flt_data_in, o_flt_sample_trig, o_snk_data, o_snk_valid, o_busy,
         o_overrun_cnt, o_underrun, o_timeout_err, o_sink_ovf} !== '0) begin
      failures++;
      $display("FAIL midwait_reset_outputs got=nonzero req=all zero (busy=%b)", o_busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    i_src_valid = 1; i_src_data = DW'(7);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_src_ready && n < 10);
    exp_q.push_back(DW'(14));
    @(negedge clk);
    i_src_valid = 0;
    i_enable = 1;
    wait_trig(200, "resume");
    checks++;
    if (o_flt_data_in !== DW'(7)) begin
      failures++;
      $display("FAIL resume_flt_in got=%h req=000007", o_flt_data_in);
    end
    repeat (45) @(negedge clk);
    i_enable = 0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL resume_result_left got=%0d req=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underrun();
    test_overrun();
    test_timeout();
    test_sink_ovf();
    test_reset_midwait();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
